mem_responder: RTL

- Multi-cycle main-memory responder: the slave end of the pipelined CPU's two memory interfaces, i.e. instruction fetch (read-only) and the memory stage (read/write).
- Serialises requests from both ports into one single-port word array with a fixed access latency.
- Returns data with a one-cycle ack pulse and supplies per-port stall signals so the pipeline can freeze while an access is outstanding.

---
 rtl/mem_responder_pkg.sv | 14 +
 rtl/mem_responder_if.sv | 28 ++
 rtl/mem_responder_array.sv | 22 ++
 rtl/mem_responder.sv | 101 ++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the two-port serialising memory responder.
package mem_responder_pkg;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
endpackage

// File: rtl/mem_responder_if.sv
// CPU-side instruction and data memory buses; master = pipeline, slave = responder.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [WORD_W-1:0] i_rdata;
  logic              i_stall;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              d_ack;
  logic [WORD_W-1:0] d_rdata;
  logic              d_stall;
  logic              busy;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall, busy
  );
endinterface

// File: rtl/mem_responder_array.sv
// Single-port synchronous word RAM; read data is registered and holds between reads.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               i_en,
  input  logic               i_we,
  input  logic [DEPTH_W-1:0] i_idx,
  input  logic [WORD_W-1:0]  i_wdata,
  output logic [WORD_W-1:0]  o_rdata
);
  logic [WORD_W-1:0] r_mem [0:(1<<DEPTH_W)-1];

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_idx] <= i_wdata;
      else      o_rdata      <= r_mem[i_idx];
    end
  end
endmodule

// File: rtl/mem_responder.sv
// Serialises instruction-fetch and data-stage requests into one RAM with a fixed
// access latency, returning a one-cycle ack and per-port stall.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_W = 10,
  parameter int LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);
  state_t             r_state, w_next;
  logic               r_port, r_we;
  logic [DEPTH_W-1:0] r_idx;
  logic [WORD_W-1:0]  r_wdata, r_i_rdata, r_d_rdata;
  logic [3:0]         r_cnt;
  logic               w_i_ack, w_d_ack, w_busy, w_fire;
  logic [WORD_W-1:0]  w_mem_rdata;
  logic               w_unused_addr;

  // Only addr[DEPTH_W:1] selects a word; the rest aliases by design.
  assign w_unused_addr = ^{bus.i_addr, bus.d_addr};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.d_req || bus.i_req) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_i_ack = (r_state == S_RESP) && (r_port == PORT_I);
    w_d_ack = (r_state == S_RESP) && (r_port == PORT_D);
    w_busy  = (r_state != S_IDLE);
    // Gating with rst keeps an abandoned write out of the array.
    w_fire  = (r_state == S_BUSY) && (r_cnt == 4'd0) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_port    <= PORT_I;
      r_we      <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 4'(LATENCY - 1);
          if (bus.d_req) begin
            r_port  <= PORT_D;
            r_we    <= bus.d_we;
            r_idx   <= bus.d_addr[DEPTH_W:1];
            r_wdata <= bus.d_wdata;
          end else if (bus.i_req) begin
            r_port  <= PORT_I;
            r_we    <= 1'b0;
            r_idx   <= bus.i_addr[DEPTH_W:1];
          end
        end
        S_BUSY: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        S_RESP: begin
          // Capture the registered RAM output so rdata holds until the next read ack.
          if (!r_we) begin
            if (r_port == PORT_D) r_d_rdata <= w_mem_rdata;
            else                  r_i_rdata <= w_mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  mem_array #(.DEPTH_W(DEPTH_W)) u_array (
    .clk     (clk),
    .i_en    (w_fire),
    .i_we    (r_we),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  assign bus.i_ack   = w_i_ack;
  assign bus.d_ack   = w_d_ack;
  assign bus.i_rdata = w_i_ack ? w_mem_rdata : r_i_rdata;
  assign bus.d_rdata = (w_d_ack && !r_we) ? w_mem_rdata : r_d_rdata;
  assign bus.i_stall = bus.i_req & ~w_i_ack;
  assign bus.d_stall = bus.d_req & ~w_d_ack;
  assign bus.busy    = w_busy;
endmodule
